mem_port_arbiter: RTL and testbench

Arbitrates the single main-memory word port between the instruction-cache refill path and the data-cache refill/writeback path of the RV32I pipeline. It runs each granted request as a LINE_WORDS-word burst and counts words through a per-word req/ack handshake. It returns read words, or pulls writeback words, tagged with a word index. It raises a one-cycle completion pulse to the owner. It sits between the two cache controllers and the memory model; the pipeline stalls on the caches' miss signals, not on this block.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the icache, dcache and memory word-port signals around mem_port_arbiter.
// master = arbiter view, slave = caches/memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_W     = 32
);
  localparam int unsigned WIDX_W = $clog2(LINE_WORDS);

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_gnt;
  logic [31:0]       ic_rdata;
  logic              ic_rvalid;
  logic [WIDX_W-1:0] ic_widx;
  logic              ic_done;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [31:0]       dc_wdata;
  logic              dc_gnt;
  logic [31:0]       dc_rdata;
  logic              dc_rvalid;
  logic [WIDX_W-1:0] dc_widx;
  logic              dc_wready;
  logic              dc_done;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
    output ic_gnt, ic_rdata, ic_rvalid, ic_widx, ic_done,
    output dc_gnt, dc_rdata, dc_rvalid, dc_widx, dc_wready, dc_done,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
    input  ic_gnt, ic_rdata, ic_rvalid, ic_widx, ic_done,
    input  dc_gnt, dc_rdata, dc_rvalid, dc_widx, dc_wready, dc_done,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Icache/dcache arbiter for the single main-memory word port; runs LINE_WORDS-word bursts.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: dcache priority).
module mem_port_arbiter #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);
  localparam int unsigned WIDX_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = WIDX_W + 2;
  localparam logic [WIDX_W-1:0] LAST = WIDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t                   state_q, state_d;
  logic [WIDX_W-1:0]        cnt_q;
  logic [ADDR_W-OFF_W-1:0]  line_q;
  logic                     we_q;
  logic                     own_dc_q;
  logic [31:0]              ic_rdata_q, dc_rdata_q;
  logic                     ic_rvalid_q, dc_rvalid_q;
  logic [WIDX_W-1:0]        ic_widx_q, dc_widx_q;
  logic                     busy, ack, start, pick_dc;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^{bus.ic_addr[OFF_W-1:0], bus.dc_addr[OFF_W-1:0]};

  assign busy  = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign ack   = busy && bus.mem_ack;
  assign start = (state_q == IDLE) && (bus.ic_req || bus.dc_req);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dc_q;

  // On a tie the requester that did not own the last burst wins.
  assign pick_dc = bus.dc_req && (!bus.ic_req || !last_dc_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dc_q <= 1'b1;
    end else if (start) begin
      last_dc_q <= pick_dc;
    end
  end
`else
  assign pick_dc = bus.dc_req;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:           if (bus.ic_req || bus.dc_req) state_d = pick_dc ? BUSY_D : BUSY_I;
      BUSY_I, BUSY_D: if (bus.mem_ack && cnt_q == LAST) state_d = DONE;
      DONE:           state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      we_q        <= 1'b0;
      own_dc_q    <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      ic_widx_q   <= '0;
      dc_widx_q   <= '0;
    end else begin
      state_q     <= state_d;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      if (start) begin
        own_dc_q <= pick_dc;
        line_q   <= pick_dc ? bus.dc_addr[ADDR_W-1:OFF_W] : bus.ic_addr[ADDR_W-1:OFF_W];
        we_q     <= pick_dc && bus.dc_we;
        cnt_q    <= '0;
      end
      if (ack) begin
        cnt_q <= cnt_q + 1'b1;
        if (own_dc_q) begin
          dc_widx_q <= cnt_q;
          if (!we_q) begin
            dc_rdata_q  <= bus.mem_rdata;
            dc_rvalid_q <= 1'b1;
          end
        end else begin
          ic_widx_q   <= cnt_q;
          ic_rdata_q  <= bus.mem_rdata;
          ic_rvalid_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.ic_gnt    = (state_q == BUSY_I) || (state_q == DONE && !own_dc_q);
    bus.dc_gnt    = (state_q == BUSY_D) || (state_q == DONE && own_dc_q);
    bus.ic_done   = (state_q == DONE) && !own_dc_q;
    bus.dc_done   = (state_q == DONE) && own_dc_q;
    bus.ic_rdata  = ic_rdata_q;
    bus.ic_rvalid = ic_rvalid_q;
    bus.ic_widx   = ic_widx_q;
    bus.dc_rdata  = dc_rdata_q;
    bus.dc_rvalid = dc_rvalid_q;
    // Writeback selects the live word; otherwise show the tag of the last acked word.
    bus.dc_widx   = (state_q == BUSY_D && we_q) ? cnt_q : dc_widx_q;
    bus.dc_wready = bus.mem_ack && (state_q == BUSY_D) && we_q;
    bus.mem_req   = busy;
    bus.mem_we    = busy && we_q;
    bus.mem_addr  = busy ? {line_q, cnt_q, 2'b00} : '0;
    bus.mem_wdata = (busy && we_q) ? bus.dc_wdata : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a gap-configurable memory model.
module tb_mem_port_arbiter;
  localparam int unsigned LW  = 8;
  localparam int unsigned AW  = 32;
  localparam int unsigned WW  = $clog2(LW);
  localparam int unsigned OFF = WW + 2;
  localparam logic [31:0] RMAGIC = 32'h5A5A_C3C3;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit DC_FIRST_ON_TIE = 1'b0;
`else
  localparam bit DC_FIRST_ON_TIE = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.LINE_WORDS(LW), .ADDR_W(AW)) bus ();
  mem_port_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   gap  = 1;
  int   wc   = 0;
  logic mack = 1'b0;
  logic spur = 1'b0;

  assign bus.mem_ack   = mack | spur;
  assign bus.mem_rdata = bus.mem_addr ^ RMAGIC;
  assign bus.dc_wdata  = 32'hDA7A_0000 + 32'(bus.dc_widx);

  always @(posedge clk) begin
    if (rst || !bus.mem_req) begin
      mack <= 1'b0;
      wc   <= 0;
    end else if (wc >= gap - 1) begin
      mack <= 1'b1;
      wc   <= 0;
    end else begin
      mack <= 1'b0;
      wc   <= wc + 1;
    end
  end

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } mreq_t;
  typedef struct { bit dc; logic [WW-1:0] widx; logic [31:0] data; } rd_t;
  mreq_t mq[$];
  rd_t   rq[$];

  int n_assert = 0, n_fail = 0, cyc = 0;
  int ic_done_n = 0, dc_done_n = 0, ic_gnt_n = 0, dc_gnt_n = 0;
  int d1, d2, g, nrv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_burst(input bit dc, input bit we, input logic [31:0] line);
    for (int unsigned i = 0; i < LW; i++) begin
      logic [31:0] a;
      mreq_t m;
      rd_t r;
      a = {line[31:OFF], WW'(i), 2'b00};
      m.addr = a; m.we = we; m.wdata = we ? 32'hDA7A_0000 + i : 32'h0;
      mq.push_back(m);
      if (!we) begin
        r.dc = dc; r.widx = WW'(i); r.data = a ^ RMAGIC;
        rq.push_back(r);
      end
    end
  endtask

  task automatic tick();
    mreq_t m;
    rd_t r;
    @(negedge clk);
    cyc++;
    if (bus.ic_gnt) ic_gnt_n++;
    if (bus.dc_gnt) dc_gnt_n++;
    if (bus.ic_done) ic_done_n++;
    if (bus.dc_done) dc_done_n++;
    if (bus.mem_req && bus.mem_ack) begin
      chk("mem_ack_expected", mq.size() != 0, 1'b1);
      if (mq.size() != 0) begin
        m = mq.pop_front();
        chk("mem_addr", bus.mem_addr, m.addr);
        chk("mem_we", bus.mem_we, m.we);
        chk("mem_wdata", bus.mem_wdata, m.wdata);
        chk("dc_wready", bus.dc_wready, m.we);
      end
    end else begin
      chk("wready_stray", bus.dc_wready, 1'b0);
    end
    if (bus.ic_rvalid || bus.dc_rvalid) begin
      chk("rvalid_expected", rq.size() != 0, 1'b1);
      if (rq.size() != 0) begin
        r = rq.pop_front();
        chk("rv_owner", {bus.dc_rvalid, bus.ic_rvalid}, r.dc ? 2'b10 : 2'b01);
        chk("rdata", r.dc ? bus.dc_rdata : bus.ic_rdata, r.data);
        chk("widx", r.dc ? bus.dc_widx : bus.ic_widx, r.widx);
        chk("done_with_last", r.dc ? bus.dc_done : bus.ic_done, r.widx == WW'(LW - 1));
      end
    end
  endtask

  task automatic wait_done(input bit dc, input int budget, output int dcyc);
    bit seen = 1'b0;
    dcyc = -1;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (dc ? bus.dc_done : bus.ic_done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    chk(dc ? "dc_done_seen" : "ic_done_seen", seen, 1'b1);
  endtask

  task automatic wait_gnt(input bit dc, input int budget, output int gcyc);
    bit seen = 1'b0;
    gcyc = -1;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (dc ? bus.dc_gnt : bus.ic_gnt) begin
        seen = 1'b1;
        gcyc = cyc;
      end
    end
    chk(dc ? "dc_gnt_seen" : "ic_gnt_seen", seen, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {bus.ic_gnt, bus.dc_gnt, bus.ic_rvalid, bus.dc_rvalid, bus.ic_done,
                        bus.dc_done, bus.mem_req, bus.mem_we, bus.dc_wready}, '0);
    chk({tag, "_rdata"}, {bus.ic_rdata, bus.dc_rdata}, '0);
    chk({tag, "_widx"}, {bus.ic_widx, bus.dc_widx}, '0);
    chk({tag, "_mem"}, {bus.mem_addr, bus.mem_wdata}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.ic_req = 1'b0; bus.ic_addr = '0;
    bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // icache refill, ack every cycle
    ic_gnt_n = 0; ic_done_n = 0;
    bus.ic_addr = 32'h0000_1234; bus.ic_req = 1'b1;
    expect_burst(1'b0, 1'b0, 32'h0000_1234);
    tick();
    chk("t1_gnt_latency", bus.ic_gnt, 1'b1);
    chk("t1_first_addr", bus.mem_addr, 32'h0000_1220);
    wait_done(1'b0, 40, d1);
    bus.ic_req = 1'b0;
    tick();
    chk("t1_gnt_drop", bus.ic_gnt, 1'b0);
    tick();
    chk("t1_gnt_cycles", ic_gnt_n, 10);
    chk("t1_done_count", ic_done_n, 1);
    chk("t1_queues_empty", mq.size() + rq.size(), 0);

    // dcache writeback, ack every 3rd cycle
    gap = 3; dc_done_n = 0;
    bus.dc_addr = 32'h8000_0040; bus.dc_we = 1'b1; bus.dc_req = 1'b1;
    expect_burst(1'b1, 1'b1, 32'h8000_0040);
    wait_done(1'b1, 100, d1);
    bus.dc_req = 1'b0; bus.dc_we = 1'b0;
    repeat (2) tick();
    chk("t2_done_count", dc_done_n, 1);
    chk("t2_queues_empty", mq.size() + rq.size(), 0);

    // simultaneous refill requests, twice
    gap = 1;
    for (int rnd = 0; rnd < 2; rnd++) begin
      bus.ic_addr = 32'h0001_0000 + 32'(rnd) * 32'h100;
      bus.dc_addr = 32'h0002_0000 + 32'(rnd) * 32'h100;
      if (DC_FIRST_ON_TIE) begin
        expect_burst(1'b1, 1'b0, bus.dc_addr);
        expect_burst(1'b0, 1'b0, bus.ic_addr);
      end else begin
        expect_burst(1'b0, 1'b0, bus.ic_addr);
        expect_burst(1'b1, 1'b0, bus.dc_addr);
      end
      bus.ic_req = 1'b1; bus.dc_req = 1'b1;
      wait_done(DC_FIRST_ON_TIE, 40, d1);
      if (DC_FIRST_ON_TIE) bus.dc_req = 1'b0; else bus.ic_req = 1'b0;
      wait_gnt(!DC_FIRST_ON_TIE, 10, g);
      chk("t3_second_gnt_gap", g - d1, 2);
      wait_done(!DC_FIRST_ON_TIE, 40, d2);
      bus.ic_req = 1'b0; bus.dc_req = 1'b0;
      repeat (2) tick();
      chk("t3_queues_empty", mq.size() + rq.size(), 0);
    end

    // icache drops req after 3 words; burst still completes
    ic_done_n = 0; nrv = 0;
    bus.ic_addr = 32'h0000_2000; bus.ic_req = 1'b1;
    expect_burst(1'b0, 1'b0, 32'h0000_2000);
    for (int k = 0; k < 30 && nrv < 3; k++) begin
      tick();
      if (bus.ic_rvalid) nrv++;
    end
    bus.ic_req = 1'b0;
    wait_done(1'b0, 40, d1);
    repeat (2) tick();
    chk("t4_done_count", ic_done_n, 1);
    chk("t4_queues_empty", mq.size() + rq.size(), 0);

    // spurious ack in IDLE
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    chk("t4_spur_ctl", {bus.ic_gnt, bus.dc_gnt, bus.ic_rvalid, bus.dc_rvalid, bus.ic_done,
                        bus.dc_done, bus.mem_req, bus.dc_wready}, '0);
    chk("t4_spur_rdata", bus.ic_rdata, 32'h0000_201C ^ RMAGIC);
    chk("t4_spur_widx", bus.ic_widx, WW'(LW - 1));

    // reset after word 4 of a dcache refill
    dc_done_n = 0; nrv = 0;
    bus.dc_addr = 32'h0000_4000; bus.dc_we = 1'b0; bus.dc_req = 1'b1;
    expect_burst(1'b1, 1'b0, 32'h0000_4000);
    for (int k = 0; k < 30 && nrv < 4; k++) begin
      tick();
      if (bus.dc_rvalid) nrv++;
    end
    chk("t5_words_before_rst", nrv, 4);
    rst = 1'b1;
    tick();
    chk_all_zero("t5_rst");
    rst = 1'b0; bus.dc_req = 1'b0;
    mq.delete(); rq.delete();
    repeat (3) tick();
    chk("t5_no_done", dc_done_n, 0);
    bus.ic_addr = 32'h0000_6000; bus.ic_req = 1'b1;
    expect_burst(1'b0, 1'b0, 32'h0000_6000);
    tick();
    chk("t5_fresh_word0", bus.mem_addr, 32'h0000_6000);
    wait_done(1'b0, 40, d1);
    bus.ic_req = 1'b0;
    repeat (2) tick();
    chk("t5_queues_empty", mq.size() + rq.size(), 0);

    // dcache request arriving while icache busy
    bus.ic_addr = 32'h0000_3000; bus.dc_addr = 32'h0000_5000;
    expect_burst(1'b0, 1'b0, 32'h0000_3000);
    expect_burst(1'b1, 1'b0, 32'h0000_5000);
    bus.ic_req = 1'b1;
    repeat (3) tick();
    bus.dc_req = 1'b1;
    tick();
    chk("t6_dc_waits", {bus.dc_gnt, bus.ic_gnt}, 2'b01);
    wait_done(1'b0, 40, d1);
    bus.ic_req = 1'b0;
    wait_gnt(1'b1, 10, g);
    chk("t6_dc_gnt_gap", g - d1, 2);
    wait_done(1'b1, 40, d2);
    bus.dc_req = 1'b0;
    repeat (2) tick();
    chk("t6_queues_empty", mq.size() + rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
